// File: rtl/acqbuf_pkg.sv
// acqbuf_pkg: shared types and helpers for the ADC capture engine.
//   state_t        capture state machine encoding (IDLE / ARMED / CAPTURE)
//   TRIG_IMMEDIATE trig_mode value: capture starts right after start
//   TRIG_EXT       trig_mode value: capture waits for a trig rising edge
//   eff_len()      maps a buffer length of 0 to the full 2**aw words
package acqbuf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic TRIG_IMMEDIATE = 1'b0;
  localparam logic TRIG_EXT       = 1'b1;

  // A length field of 0 cannot be represented as a word count in aw bits,
  // so it is taken to mean the whole buffer.
  function automatic logic [31:0] eff_len(input logic [31:0] len, input int unsigned aw);
    return (len == 32'd0) ? (32'd1 << aw) : len;
  endfunction

endpackage

// File: rtl/acqbuf_wr_if.sv
// acqbuf_wr_if: ADC stream lanes plus the BRAM write port of the capture engine.
//   s_valid/s_data/s_ready  NCHAN aligned AXI-stream lanes (data lane i at
//                           bits [(i+1)*SAMPLE_WIDTH-1 : i*SAMPLE_WIDTH])
//   bram_en/we/addr/din     BRAM write port
//   modport slave  : capture engine view (consumes the stream, drives BRAM)
//   modport master : source / observer view (drives the stream, sees BRAM)
interface acqbuf_wr_if #(
  parameter int NCHAN        = 4,
  parameter int SAMPLE_WIDTH = 64,
  parameter int ADDR_WIDTH   = 13
);
  localparam int DW = NCHAN * SAMPLE_WIDTH;

  logic [NCHAN-1:0]      s_valid;
  logic [DW-1:0]         s_data;
  logic [NCHAN-1:0]      s_ready;
  logic                  bram_en;
  logic [DW/8-1:0]       bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DW-1:0]         bram_din;

  modport master (
    output s_valid, s_data,
    input  s_ready, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, bram_en, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/acqbuf_decim.sv
// acqbuf_decim: decimation counter for the capture engine.
//   clk, aresetn  clock / asynchronous active-low reset
//   clr           forces the counter to 0 (held while not capturing)
//   en            one accepted beat this cycle
//   ratio         decimation ratio; one beat in every ratio+1 is kept
//   wr_stb        high when the current accepted beat is to be written
module acqbuf_decim #(
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   clr,
  input  logic                   en,
  input  logic [DECIM_WIDTH-1:0] ratio,
  output logic                   wr_stb
);

  logic [DECIM_WIDTH-1:0] cnt_reg;

  // Counter sits at 0 on entry, so the first accepted beat is always kept.
  assign wr_stb = en && (cnt_reg == '0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == ratio) ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/acqbuf_wr.sv
// acqbuf_wr: multi-channel ADC capture engine writing aligned lanes to BRAM.
//   clk, aresetn   dsp clock / asynchronous active-low reset
//   bus            stream lanes in, BRAM write port out (acqbuf_wr_if.slave)
//   start, abort   one-cycle control pulses (abort wins)
//   trig           external trigger; trig_mode selects immediate / edge start
//   cont           continuous ring mode
//   decim, length  decimation ratio and buffer length (0 = full depth)
//   busy           ARMED or CAPTURE
//   done           sticky single-shot completion flag
//   wr_count       words written in the current buffer
//   frame_count    buffers completed since start (wraps)
//   skew_err       sticky; lane valids disagreed during capture
module acqbuf_wr
  import acqbuf_pkg::*;
#(
  parameter int NCHAN        = 4,
  parameter int SAMPLE_WIDTH = 64,
  parameter int ADDR_WIDTH   = 13,
  parameter int DECIM_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  acqbuf_wr_if.slave             bus,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   trig,
  input  logic                   trig_mode,
  input  logic                   cont,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic [ADDR_WIDTH-1:0]  length,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    wr_count,
  output logic [15:0]            frame_count,
  output logic                   skew_err
);

  localparam int DW = NCHAN * SAMPLE_WIDTH;
  localparam int BW = DW / 8;
  localparam int CW = ADDR_WIDTH + 1;

  state_t                 state_reg;
  logic [DECIM_WIDTH-1:0] decim_reg;
  logic [CW-1:0]          len_reg;
  logic                   cont_reg;
  logic                   trig_prev_reg;
  logic                   bram_en_reg;
  logic [BW-1:0]          bram_we_reg;
  logic [ADDR_WIDTH-1:0]  bram_addr_reg;
  logic [DW-1:0]          bram_din_reg;
  logic                   done_reg;
  logic [CW-1:0]          wr_count_reg;
  logic [15:0]            frame_count_reg;
  logic                   skew_err_reg;

  logic beat_ok;
  logic lane_skew;
  logic in_capture;
  logic wr_stb;
  logic wr_last;

  assign beat_ok    = &bus.s_valid;
  assign lane_skew  = (|bus.s_valid) && !beat_ok;
  assign in_capture = (state_reg == CAPTURE);
  assign wr_last    = (wr_count_reg == len_reg - 1'b1);

  // The ADC cannot be back-pressured, so ready is tied high.
  assign bus.s_ready   = '1;
  assign bus.bram_en   = bram_en_reg;
  assign bus.bram_we   = bram_we_reg;
  assign bus.bram_addr = bram_addr_reg;
  assign bus.bram_din  = bram_din_reg;

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign wr_count    = wr_count_reg;
  assign frame_count = frame_count_reg;
  assign skew_err    = skew_err_reg;

  // Held clear outside CAPTURE so the counter is 0 on every entry; an abort
  // cycle must not consume a beat.
  acqbuf_decim #(
    .DECIM_WIDTH(DECIM_WIDTH)
  ) u_decim (
    .clk    (clk),
    .aresetn(aresetn),
    .clr    (!in_capture),
    .en     (in_capture && beat_ok && !abort),
    .ratio  (decim_reg),
    .wr_stb (wr_stb)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      decim_reg       <= '0;
      len_reg         <= '0;
      cont_reg        <= 1'b0;
      trig_prev_reg   <= 1'b0;
      bram_en_reg     <= 1'b0;
      bram_we_reg     <= '0;
      bram_addr_reg   <= '0;
      bram_din_reg    <= '0;
      done_reg        <= 1'b0;
      wr_count_reg    <= '0;
      frame_count_reg <= '0;
      skew_err_reg    <= 1'b0;
    end else begin
      bram_en_reg   <= 1'b0;
      bram_we_reg   <= '0;
      // Tracked in every state so the level seen before arming counts as
      // history: a trigger already high at start is not an edge.
      trig_prev_reg <= trig;

      if (abort) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              decim_reg       <= decim;
              len_reg         <= CW'(eff_len(32'(length), ADDR_WIDTH));
              cont_reg        <= cont;
              done_reg        <= 1'b0;
              skew_err_reg    <= 1'b0;
              wr_count_reg    <= '0;
              frame_count_reg <= '0;
              state_reg       <= (trig_mode == TRIG_EXT) ? ARMED : CAPTURE;
            end
          end

          ARMED: begin
            if (trig && !trig_prev_reg) begin
              state_reg <= CAPTURE;
            end
          end

          CAPTURE: begin
            if (lane_skew) begin
              skew_err_reg <= 1'b1;
            end
            if (wr_stb) begin
              bram_en_reg   <= 1'b1;
              bram_we_reg   <= '1;
              bram_addr_reg <= wr_count_reg[ADDR_WIDTH-1:0];
              bram_din_reg  <= bus.s_data;
              if (wr_last) begin
                frame_count_reg <= frame_count_reg + 16'd1;
                if (cont_reg) begin
                  // Ring wrap: the next beat goes straight to address 0.
                  wr_count_reg <= '0;
                end else begin
                  wr_count_reg <= wr_count_reg + 1'b1;
                  done_reg     <= 1'b1;
                  state_reg    <= IDLE;
                end
              end else begin
                wr_count_reg <= wr_count_reg + 1'b1;
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acqbuf_wr.sv
// tb_acqbuf_wr: directed, table-driven bench for acqbuf_wr (NCHAN=4,
// SAMPLE_WIDTH=64, ADDR_WIDTH=13). Lane i of beat b carries {i, b}.
module tb_acqbuf_wr;

  localparam int NCHAN = 4;
  localparam int SW    = 64;
  localparam int AW    = 13;
  localparam int DWID  = 8;
  localparam int DW    = NCHAN * SW;

  logic            clk;
  logic            aresetn;
  logic            start;
  logic            abort;
  logic            trig;
  logic            trig_mode;
  logic            cont;
  logic [DWID-1:0] decim;
  logic [AW-1:0]   length;
  logic            busy;
  logic            done;
  logic [AW:0]     wr_count;
  logic [15:0]     frame_count;
  logic            skew_err;

  acqbuf_wr_if #(.NCHAN(NCHAN), .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) bus ();

  acqbuf_wr #(
    .NCHAN(NCHAN), .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .DECIM_WIDTH(DWID)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .bus        (bus),
    .start      (start),
    .abort      (abort),
    .trig       (trig),
    .trig_mode  (trig_mode),
    .cont       (cont),
    .decim      (decim),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .frame_count(frame_count),
    .skew_err   (skew_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write monitor: every BRAM write lands in the queues; stray byte enables
  // on non-write cycles and partial enables on write cycles are counted.
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int we_err = 0;

  always @(negedge clk) begin
    if (bus.bram_en === 1'b1) begin
      wa_q.push_back(bus.bram_addr);
      wd_q.push_back(bus.bram_din);
      if (bus.bram_we !== {(DW/8){1'b1}}) we_err++;
    end else if (bus.bram_we !== '0) begin
      we_err++;
    end
  end

  function automatic logic [DW-1:0] mk(input int b);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < NCHAN; i++) begin
      v[i*SW +: SW] = {32'(i), 32'(b)};
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int k = 0; k < n; k++) begin
      bus.s_valid = '1;
      bus.s_data  = mk(k);
      tick();
    end
    bus.s_valid = '0;
    bus.s_data  = '0;
  endtask

  typedef struct {
    logic tm;
    logic cont;
    int   decim;
    int   len;      // value driven on length (0 = full buffer)
    int   eff;      // hand-computed effective length
    int   nbeats;
    int   exp_nwr;
    logic exp_done;
    int   exp_frame;
    int   exp_wrc;
    logic exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int nw;
    int bad;
    int beat;

    aresetn     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    trig        = 1'b0;
    trig_mode   = 1'b0;
    cont        = 1'b0;
    decim       = '0;
    length      = '0;
    bus.s_valid = '0;
    bus.s_data  = '0;

    //            tm    cont  dec len eff   beats  nwr   done  frm wrc   busy
    vecs[0] = '{1'b0, 1'b0, 0, 16, 16,   20,    16,   1'b1, 1,  16,   1'b0};
    vecs[1] = '{1'b0, 1'b0, 2, 4,  4,    12,    4,    1'b1, 1,  4,    1'b0};
    vecs[2] = '{1'b0, 1'b1, 0, 8,  8,    20,    20,   1'b0, 2,  4,    1'b1};
    vecs[3] = '{1'b0, 1'b1, 1, 4,  4,    12,    6,    1'b0, 1,  2,    1'b1};
    vecs[4] = '{1'b0, 1'b0, 0, 0,  8192, 8200,  8192, 1'b1, 1,  8192, 1'b0};

    // Reset values, sampled while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_skew_err", 64'(skew_err), 64'd0);
    chk("rst_bram_en", 64'(bus.bram_en), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'hF);
    aresetn = 1'b1;
    tick();

    // Table-driven captures.
    for (int v = 0; v < 5; v++) begin
      trig_mode = vecs[v].tm;
      cont      = vecs[v].cont;
      decim     = DWID'(vecs[v].decim);
      length    = AW'(vecs[v].len);
      base      = wa_q.size();
      pulse_start();
      send_beats(vecs[v].nbeats);
      repeat (3) tick();
      nw  = wa_q.size() - base;
      bad = 0;
      for (int n = 0; n < nw && n < vecs[v].exp_nwr; n++) begin
        beat = n * (vecs[v].decim + 1);
        if (wa_q[base+n] !== AW'(n % vecs[v].eff) || wd_q[base+n] !== mk(beat)) begin
          if (bad == 0)
            $display("vec%0d write %0d: addr %0d data %0h, wanted addr %0d beat %0d",
                     v, n, wa_q[base+n], wd_q[base+n][31:0], n % vecs[v].eff, beat);
          bad++;
        end
      end
      $display("vec%0d: tm=%0d cont=%0d decim=%0d len=%0d beats=%0d -> %0d writes",
               v, vecs[v].tm, vecs[v].cont, vecs[v].decim, vecs[v].len, vecs[v].nbeats, nw);
      chk($sformatf("vec%0d_nwrites", v), 64'(nw), 64'(vecs[v].exp_nwr));
      chk($sformatf("vec%0d_bad_writes", v), 64'(bad), 64'd0);
      chk($sformatf("vec%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
      chk($sformatf("vec%0d_frame_count", v), 64'(frame_count), 64'(vecs[v].exp_frame));
      chk($sformatf("vec%0d_wr_count", v), 64'(wr_count), 64'(vecs[v].exp_wrc));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
      if (vecs[v].cont) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk($sformatf("vec%0d_busy_after_abort", v), 64'(busy), 64'd0);
      end
    end

    // External trigger: high before arming, falls, rises again at beat 10.
    trig_mode = 1'b1;
    cont      = 1'b0;
    decim     = '0;
    length    = AW'(4);
    trig      = 1'b1;
    base      = wa_q.size();
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (k == 9) begin
        chk("trig_busy_armed", 64'(busy), 64'd1);
        chk("trig_no_early_writes", 64'(wa_q.size() - base), 64'd0);
      end
      bus.s_valid = '1;
      bus.s_data  = mk(k);
      trig        = (k < 5 || k >= 10);
      tick();
    end
    bus.s_valid = '0;
    trig        = 1'b0;
    repeat (2) tick();
    nw = wa_q.size() - base;
    $display("trig: %0d writes after edge at beat 10", nw);
    chk("trig_nwrites", 64'(nw), 64'd4);
    if (nw == 4) begin
      chk("trig_first_data", wd_q[base][63:0], mk(11)[63:0]);
      chk("trig_last_data", wd_q[base+3][63:0], mk(14)[63:0]);
      chk("trig_last_addr", 64'(wa_q[base+3]), 64'd3);
    end
    chk("trig_done", 64'(done), 64'd1);

    // Lane skew: lane 2 drops valid on beat 3.
    trig_mode = 1'b0;
    length    = AW'(8);
    base      = wa_q.size();
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      bus.s_valid = (k == 3) ? 4'b1011 : 4'b1111;
      bus.s_data  = mk(k);
      tick();
    end
    bus.s_valid = '0;
    repeat (2) tick();
    nw = wa_q.size() - base;
    $display("skew: %0d writes, skew_err=%0d", nw, skew_err);
    chk("skew_err", 64'(skew_err), 64'd1);
    chk("skew_nwrites", 64'(nw), 64'd8);
    if (nw == 8) begin
      chk("skew_addr3", 64'(wa_q[base+3]), 64'd3);
      chk("skew_data3", wd_q[base+3][63:0], mk(4)[63:0]);
      chk("skew_data7", wd_q[base+7][63:0], mk(8)[63:0]);
    end

    // Abort after 5 writes, with start in the same cycle.
    length = AW'(16);
    base   = wa_q.size();
    pulse_start();
    chk("abort_skew_cleared", 64'(skew_err), 64'd0);
    send_beats(5);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wr_count", 64'(wr_count), 64'd5);
    chk("abort_done", 64'(done), 64'd0);
    send_beats(3);
    tick();
    $display("abort: %0d writes, wr_count=%0d", wa_q.size() - base, wr_count);
    chk("abort_start_ignored", 64'(busy), 64'd0);
    chk("abort_nwrites", 64'(wa_q.size() - base), 64'd5);

    // Asynchronous reset in the middle of a capture.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      bus.s_valid = '1;
      bus.s_data  = mk(k);
      tick();
    end
    chk("rst_mid_en_before", 64'(bus.bram_en), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    $display("mid-capture reset: busy=%0d wr_count=%0d en=%0d", busy, wr_count, bus.bram_en);
    chk("rst_mid_bram_en", 64'(bus.bram_en), 64'd0);
    chk("rst_mid_wr_count", 64'(wr_count), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_frame_count", 64'(frame_count), 64'd0);
    chk("rst_mid_s_ready", 64'(bus.s_ready), 64'hF);
    bus.s_valid = '0;
    tick();
    aresetn = 1'b1;
    tick();

    chk("byte_enable_errors", 64'(we_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acqbuf_wr.md
Name: acqbuf_wr

Overview:
- Parametrised multi-channel ADC capture engine: takes NCHAN aligned ADC AXI-stream slave lanes and writes them into a BRAM write port, with decimation, trigger and continuous ring modes.
- Successor to the fixed four-BRAM write mapping: channel count, sample width and buffer depth are generic.
- Sits between the ADC AXI-stream slave maps and the PS-readable BRAM_WRITE ports.
- Controlled and observed through localbus registers in the dsp clock domain.

Parameters:
- NCHAN, 4, number of ADC lanes captured side by side.
- SAMPLE_WIDTH, 64, bits per lane per beat.
- ADDR_WIDTH, 13, BRAM word address width; buffer depth is 2**ADDR_WIDTH.
- DECIM_WIDTH, 8, width of the decimation ratio field.

Ports:
- clk  in  1  dsp clock; all logic on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_valid  in  NCHAN  per-lane AXI-stream tvalid.
- s_data  in  NCHAN*SAMPLE_WIDTH  lane i occupies bits [(i+1)*SAMPLE_WIDTH-1 : i*SAMPLE_WIDTH].
- s_ready  out  NCHAN  tready; constant all-ones after reset (ADC never stalls).
- start  in  1  one-cycle pulse that arms a capture.
- abort  in  1  one-cycle pulse that returns the block to IDLE.
- trig  in  1  external trigger, synchronous to clk.
- trig_mode  in  1  0 = capture immediately after start; 1 = wait for a trig rising edge.
- cont  in  1  1 = continuous ring mode.
- decim  in  DECIM_WIDTH  write every (decim+1)th accepted beat.
- length  in  ADDR_WIDTH  words per buffer; 0 means 2**ADDR_WIDTH.
- bram_en  out  1  BRAM enable.
- bram_we  out  NCHAN*SAMPLE_WIDTH/8  byte write enables.
- bram_addr  out  ADDR_WIDTH  BRAM word address.
- bram_din  out  NCHAN*SAMPLE_WIDTH  BRAM write data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  sticky; set on completion of a single-shot capture.
- wr_count  out  ADDR_WIDTH+1  words written in the current buffer.
- frame_count  out  16  buffers completed since start; wraps.
- skew_err  out  1  sticky; lane valids disagreed during CAPTURE.

Behaviour:
- Reset, async assert and sync release: all outputs 0 except s_ready = all-ones; state IDLE.
- Accepted beat: every bit of s_valid high (&s_valid).
- Skew: in CAPTURE, s_valid neither all-0 nor all-1 sets skew_err; that beat is dropped. Cleared by start.
- IDLE:
  - start latches decim, length, cont and trig_mode; clears done, skew_err, wr_count and frame_count.
  - Next state is CAPTURE if trig_mode=0, otherwise ARMED.
- ARMED: trig high now and low the previous cycle -> CAPTURE. The trig level before arming is sampled, so a trigger already high at arm time is not an edge.
- CAPTURE:
  - Decimation counter is cleared on entry, so the first accepted beat is always written.
  - Each accepted beat with counter==0 is written; counter counts 0..decim and then wraps.
  - Write is registered, 1-cycle latency: bram_en=1, bram_we=all-ones, bram_addr=wr_count[ADDR_WIDTH-1:0], bram_din=s_data, then wr_count++.
  - bram_en and bram_we are 0 on all non-write cycles.
- Buffer full, on the write with wr_count = effective length-1:
  - cont=0: frame_count++, done=1, next state IDLE.
  - cont=1: frame_count++, wr_count=0, address wraps to 0, stay in CAPTURE; no beat is lost across the wrap.
- abort: highest priority in any state. Next state IDLE; a write already registered still completes; done is not set; wr_count holds its value.
- start while busy is ignored. start and abort in the same cycle resolve to abort.
- Changing the latched inputs mid-capture has no effect until the next start.
- length=0 with ADDR_WIDTH=13 gives 8192 words.

Decomposition:
- Package acqbuf_pkg:
  - state enum IDLE/ARMED/CAPTURE.
  - Localparams TRIG_IMMEDIATE=0 and TRIG_EXT=1.
  - Function eff_len(length) that maps 0 to 2**ADDR_WIDTH.
- Sub-module acqbuf_decim: decimation counter with clear, enable and ratio inputs; outputs a write strobe.

Test Plan:
- NCHAN=4, trig_mode=0, cont=0, decim=0, length=16; 20 contiguous beats with lane i = {i, beat#} -> 16 writes to addr 0..15 of beats 0..15; done=1; frame_count=1; busy=0.
- decim=2, length=4, 12 beats -> beats 0,3,6,9 written to addr 0..3.
- trig_mode=1, trig held high before start, then falling and rising again at cycle 10 -> no writes before cycle 10; first written beat is the one accepted after the edge.
- cont=1, length=8, 20 beats -> addresses 0..7,0..7,0..3; frame_count=2; done stays 0.
- Lane 2 valid low for one cycle mid-capture -> skew_err=1, that beat is skipped, the next beat is written at the following address.
- abort after 5 writes with length=16 -> state IDLE, wr_count=5, done=0. start in the same cycle as abort is ignored. aresetn asserted mid-capture -> all outputs cleared immediately.
